// File: rtl/reg_pipe_chain.sv
// Chain of DEPTH registered stages with valid/ready flow control, flush and synchronous reset.
// Stage enables come from a bubble-collapsing ready chain driven by downstream backpressure.
module reg_pipe_chain #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("reg_pipe_chain: DEPTH must be at least 1");
        end
    endgenerate

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]               occ_q, occ_d;

    // A stage may load when any stage at or after it is empty, or the sink is ready.
    always_comb begin
        logic bub;
        rdy = '0;
        bub = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            bub    = bub | ~v_q[i];
            rdy[i] = bub;
        end
    end

    assign in_ready = rdy[0] & ~flush;

    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        occ_d = '0;
        if (flush) begin
            v_d = '0;
        end else begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                if (in_valid) begin
                    d_d[0] = in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
                    end
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            d_q   <= {DEPTH{RESET_VAL}};
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Self-checking bench for reg_pipe_chain: directed scenarios plus randomized traffic
// compared against a queue-based model of item positions.
module tb_reg_pipe_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [2:0]       occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    reg_pipe_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Model: items oldest first, each with the stage index it currently sits in.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } item_t;

    item_t            q[$];
    logic [WIDTH-1:0] m_out = 8'h00;

    function automatic logic exp_in_ready();
        return !flush && ((q.size() < DEPTH) || out_ready);
    endfunction

    function automatic logic exp_out_valid();
        return (q.size() > 0) && (q[0].pos == DEPTH - 1);
    endfunction

    // An item moves on when the sink is ready or the stages ahead of it are not all full.
    function automatic void model_update();
        logic  acc;
        logic  leave;
        item_t it;
        if (rst) begin
            q.delete();
            m_out = 8'h00;
            return;
        end
        acc = in_valid && exp_in_ready();
        if (flush) begin
            q.delete();
            return;
        end
        leave = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            it = q[k];
            if (it.pos == DEPTH - 1) begin
                if (out_ready) leave = 1'b1;
            end else if (out_ready || (k < DEPTH - 1 - it.pos)) begin
                it.pos = it.pos + 1;
                if (it.pos == DEPTH - 1) m_out = it.data;
                q[k] = it;
            end
        end
        if (leave) void'(q.pop_front());
        if (acc) begin
            it.data = in_data;
            it.pos  = 0;
            if (DEPTH == 1) m_out = in_data;
            q.push_back(it);
        end
    endfunction

    task automatic set_in(input logic r, input logic f, input logic iv,
                          input logic [WIDTH-1:0] id, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
            advance();
        end
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy);
        else n_pass++;
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_latency();
        int exp_occ;
        for (int t = 1; t <= 12; t++) begin
            if (t <= 8) set_in(1'b0, 1'b0, 1'b1, 8'(t), 1'b1);
            else        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL lat_in_ready t=%0d: got %b want 1", t, in_ready);
            else n_pass++;
            advance();
            exp_occ = ((t < 8) ? t : 8) - ((t > 4) ? t - 4 : 0);
            n_checks++;
            if (out_valid !== ((t >= 4) && (t <= 11)))
                $display("FAIL lat_out_valid t=%0d: got %b want %b", t, out_valid,
                         ((t >= 4) && (t <= 11)));
            else n_pass++;
            n_checks++;
            if (occupancy !== 3'(exp_occ))
                $display("FAIL lat_occupancy t=%0d: got %0d want %0d", t, occupancy, exp_occ);
            else n_pass++;
            if (t >= 4 && t <= 11) begin
                n_checks++;
                if (out_data !== 8'(t - 3))
                    $display("FAIL lat_out_data t=%0d: got %h want %h", t, out_data, 8'(t - 3));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 1'b0, 1'b1, 8'h10 + 8'(k), 1'b0);
            advance();
        end
        set_in(1'b0, 1'b0, 1'b1, 8'h14, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", in_ready);
        else n_pass++;
        advance();
        n_checks++;
        if (occupancy !== 3'd4) $display("FAIL bp_occupancy: got %0d want 4", occupancy);
        else n_pass++;
        n_checks++;
        if (out_data !== 8'h10 || out_valid !== 1'b1)
            $display("FAIL bp_hold: got %h/%b want 10/1", out_data, out_valid);
        else n_pass++;
        set_in(1'b0, 1'b0, 1'b1, 8'h14, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
        else n_pass++;
        advance();
        n_checks++;
        if (occupancy !== 3'd4) $display("FAIL bp_swap_occupancy: got %0d want 4", occupancy);
        else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (out_data !== 8'h10 + 8'(k) || out_valid !== 1'b1)
                $display("FAIL bp_drain_%0d: got %h/%b want %h/1", k, out_data, out_valid,
                         8'h10 + 8'(k));
            else n_pass++;
            set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            advance();
        end
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_bubble();
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        set_in(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
        advance();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        advance();
        set_in(1'b0, 1'b0, 1'b1, 8'h21, 1'b0);
        advance();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        advance();
        n_checks++;
        if (occupancy !== 3'd2) $display("FAIL bub_occupancy: got %0d want 2", occupancy);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bub_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h20)
            $display("FAIL bub_head: got %b/%h want 1/20", out_valid, out_data);
        else n_pass++;
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        advance();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h21)
            $display("FAIL bub_second: got %b/%h want 1/21", out_valid, out_data);
        else n_pass++;
        advance();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, 1'b1, 8'h30 + 8'(k), 1'b0);
            advance();
        end
        set_in(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready);
        else n_pass++;
        advance();
        n_checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL flush_clear: got occ=%0d valid=%b want 0/0", occupancy, out_valid);
        else n_pass++;
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            advance();
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL flush_no_emit_%0d: got %b want 0", k, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 1'b0, 1'b1, 8'h40 + 8'(k), 1'b0);
            advance();
        end
        set_in(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        advance();
        n_checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL rstmid_outputs: got occ=%0d valid=%b data=%h want 0/0/00",
                     occupancy, out_valid, out_data);
        else n_pass++;
        for (int t = 1; t <= 5; t++) begin
            set_in(1'b0, 1'b0, (t == 1), 8'h50, 1'b1);
            advance();
            n_checks++;
            if (out_valid !== (t == 4) || (t == 4 && out_data !== 8'h50))
                $display("FAIL rstmid_flow t=%0d: got %b/%h want %b/50", t, out_valid, out_data,
                         (t == 4));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(99) == 0), ($urandom_range(39) == 0),
                   ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 6));
            #1;
            n_checks++;
            if (in_ready !== exp_in_ready())
                $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, exp_in_ready());
            else n_pass++;
            advance();
            n_checks++;
            if (out_valid !== exp_out_valid())
                $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid,
                         exp_out_valid());
            else n_pass++;
            n_checks++;
            if (out_data !== m_out)
                $display("FAIL rnd_out_data c=%0d: got %h want %h", c, out_data, m_out);
            else n_pass++;
            n_checks++;
            if (occupancy !== 3'(q.size()))
                $display("FAIL rnd_occupancy c=%0d: got %0d want %0d", c, occupancy, q.size());
            else n_pass++;
        end
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        test_reset();
        test_latency();
        test_backpressure();
        test_bubble();
        test_flush();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_pipe_chain.md
Name: reg_pipe_chain

Overview:
- Parametrised successor to the single-bit enabled D flip-flop: a chain of DEPTH registered stages, each WIDTH bits wide, with valid/ready flow control.
- Each stage's enable is derived from downstream backpressure (bubble-collapsing), replacing the manual `en` wire.
- Used between datapath blocks that need a fixed register delay with stall and flush support.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages (>=1; DEPTH=0 is illegal and must trip an elaboration-time error)
- RESET_VAL, 0, value loaded into every stage's data register on reset

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous: drop all in-flight items
- in_valid  input  1  upstream has data
- in_ready  output  1  chain accepts data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds a valid item
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  last-stage data
- occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State per stage i (0..DEPTH-1):
  - v[i], valid bit
  - d[i], WIDTH-bit data register
  - Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data.
- Ready chain (combinational):
  - r[DEPTH] = out_ready
  - r[i] = !v[i] | r[i+1]
  - in_ready = r[0] & !flush
  - A bubble anywhere lets upstream stages advance (bubble collapsing).
  - The ready path is combinational from out_ready to in_ready through the chain, by design.
- Stage update, when not rst and not flush:
  - Stage 0 enable: e[0] = r[0]. If e[0]: v[0] <= in_valid; d[0] <= in_data only if in_valid, otherwise d[0] holds.
  - Stage i>0 enable: e[i] = r[i]. If e[i]: v[i] <= v[i-1]; d[i] <= d[i-1] only if v[i-1], otherwise d[i] holds.
  - A stage whose e[i]=0 holds v and d, as the single DFF does with en=0.
- Handshakes:
  - Input transfer: in_valid & in_ready at the edge.
  - Output transfer: out_valid & out_ready.
  - in_valid may rise or fall at any time. Items are never duplicated, dropped or reordered, except by flush or rst.
- Latency:
  - Empty chain with out_ready held high: an item accepted at edge k is visible on out_data/out_valid after edge k+DEPTH-1, i.e. DEPTH edges counting the accept edge.
  - Throughput is 1 item/cycle while out_ready=1.
- out_data = d[DEPTH-1] always. Its value is only meaningful while out_valid=1.
- occupancy:
  - Registered count of the set v[i], updated on the same edge as v.
  - Equals the popcount of v after every edge.
  - Reset value 0.
- flush:
  - On the edge: all v[i] <= 0 and occupancy <= 0; d registers hold.
  - in_ready is forced 0 while flush=1, so a simultaneous input is not accepted.
  - out_valid still reflects pre-flush state in that cycle. A simultaneous output transfer counts as completed.
- rst:
  - Has priority over flush and all traffic.
  - On the edge: v[i] <= 0, d[i] <= RESET_VAL, occupancy <= 0.
  - Reset values: out_valid=0, out_data=RESET_VAL, occupancy=0. in_ready=1 after reset once rst=0 and flush=0.
  - Reset mid-stream discards all items.
- Full chain (occupancy=DEPTH) with out_ready=0: in_ready=0 and everything holds.
  - Full chain with out_ready=1: simultaneous accept and emit; occupancy unchanged.
- DEPTH=1: degenerates to a single register.
  - in_ready = !v[0] | out_ready.
  - Latency 1.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_data=8'hAA -> out_valid=0, out_data=8'h00, occupancy=0; in_ready=1 on the first cycle after rst falls.
- Latency/throughput (DEPTH=4, out_ready=1): send 8'h01..8'h08 on consecutive cycles -> 8'h01 appears after 4 edges, then one item per cycle in order; occupancy steady at 4.
- Backpressure: fill with 8'h10..8'h13, out_ready=0 -> occupancy=4, in_ready=0, out_data=8'h10 held. Raise out_ready for 1 cycle -> 8'h10 emitted, next input accepted the same cycle.
- Bubble collapse: out_ready=0, send 8'h20 then a 2-cycle gap then 8'h21 -> both items pack into stages 3 and 2 (occupancy=2 with in_ready still 1).
- Flush: with occupancy=3, assert flush together with in_valid=1 and in_data=8'h55 -> next cycle occupancy=0 and out_valid=0; 8'h55 is never emitted.
- Reset mid-operation: assert rst with occupancy=4 and flush=1 -> rst wins; all outputs return to reset values and later inputs flow normally.
